// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_program_loader_pkg;

    localparam int LEN_W      = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // Status flags that are a pure function of the state, registered together.
    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic core_hold;
        logic done;
        logic error;
    } flags_t;

    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            LEN_LO, LEN_HI, DATA, CHK: begin
                f.rx_ready  = 1'b1;
                f.busy      = 1'b1;
                f.core_hold = 1'b1;
            end
            WRITE: begin
                f.busy      = 1'b1;
                f.core_hold = 1'b1;
            end
            DONE: f.done = 1'b1;
            ERR: begin
                f.error     = 1'b1;
                f.core_hold = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Packs incoming bytes little-endian into 32-bit words and counts bytes per word.
module loader_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_complete
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]          byte_cnt;
    logic [8*WORD_BYTES-1:0]   word_q;

    // Current word with the incoming byte merged into its lane; valid as the full
    // word in the same cycle as the last byte so the write needs no extra stage.
    always_comb begin
        word_next = word_q;
        word_next[8*byte_cnt +: 8] = byte_in;
    end

    assign word_complete = byte_en && (byte_cnt == CNT_W'(WORD_BYTES - 1));

    // Lane storage and byte counter; the counter wraps after the last lane.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (byte_en) begin
            word_q   <= word_next;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes it into
// instruction memory while holding the core's fetch stage in reset.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | no session since reset
// LEN_LO | waiting for word count bits [7:0]
// LEN_HI | waiting for word count bits [15:8], range check
// DATA   | collecting the 4 bytes of the next word
// WRITE  | one-cycle memory write of the assembled word
// CHK    | waiting for the checksum byte
// DONE   | session completed, core released
// ERR    | bad length or checksum, core kept in reset
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [LEN_W:0] DEPTH_LIM = (LEN_W + 1)'(IMEM_DEPTH);

    state_t           state;
    state_t           state_nxt;
    flags_t           flags_nxt;
    logic [LEN_W-1:0] word_count;
    logic [LEN_W-1:0] word_index;
    logic [LEN_W-1:0] index_inc;
    logic [LEN_W-1:0] len_rx;
    logic [7:0]       len_lo;
    logic [7:0]       csum;
    logic             xfer;
    logic             start_ok;
    logic             asm_en;
    logic             word_complete;
    logic [31:0]      word_next;

    assign xfer      = rx_valid && rx_ready;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    assign asm_en    = xfer && (state == DATA);
    assign len_rx    = {rx_data, len_lo};
    assign index_inc = word_index + 1'b1;
    assign flags_nxt = flags_of(state_nxt);

    loader_word_assembler u_asm (
        .clk           (clk),
        .rst           (rst),
        .clear         (start_ok),
        .byte_en       (asm_en),
        .byte_in       (rx_data),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    // Next-state decode; every byte-consuming state stalls while no byte transfers.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
            LEN_LO:          if (xfer) state_nxt = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_rx == '0)                   state_nxt = CHK;
                    else if ({1'b0, len_rx} > DEPTH_LIM) state_nxt = ERR;
                    else                                 state_nxt = DATA;
                end
            end
            DATA:            if (word_complete) state_nxt = WRITE;
            WRITE:           state_nxt = (index_inc == word_count) ? CHK : DATA;
            CHK:             if (xfer) state_nxt = (rx_data == csum) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    // State, session datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word_count   <= '0;
            word_index   <= '0;
            len_lo       <= '0;
            csum         <= '0;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            core_hold    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
        end else begin
            state <= state_nxt;
            {rx_ready, busy, core_hold, done, error} <= flags_nxt;
            imem_wr_en <= 1'b0;

            if (start_ok) begin
                word_index <= '0;
                word_count <= '0;
                csum       <= '0;
            end
            if (xfer && state == LEN_LO) len_lo     <= rx_data;
            if (xfer && state == LEN_HI) word_count <= len_rx;
            if (asm_en)                  csum       <= csum + rx_data;

            // Address and data only change with a write, so they hold afterwards.
            if (asm_en && word_complete) begin
                imem_wr_en   <= 1'b1;
                imem_wr_addr <= ADDR_BASE + 32'({word_index, 2'b00});
                imem_wr_data <= word_next;
            end
            if (state == WRITE) word_index <= index_inc;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_w;

    imem_program_loader #(.IMEM_DEPTH(256), .ADDR_BASE(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe pops one expected {addr, data}.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            wr_count++;
            checks++;
            if (rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL write_rx_ready got=%b want=0", rx_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h want=no_write", imem_wr_addr, imem_wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({imem_wr_addr, imem_wr_data} !== exp_w) begin
                    failures++;
                    $display("FAIL write addr/data got=%h/%h want=%h/%h",
                             imem_wr_addr, imem_wr_data, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  n;
        int  idle;
        bit  sampled;
        idle = 0;
        while (rnd && $urandom_range(1, 0) == 0 && idle < 8) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
            idle++;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        forever begin
            sampled = rx_ready;
            @(posedge clk); #1;
            if (sampled) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL byte_accept_timeout byte=%h got=not_accepted want=accepted", b);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit rnd);
        foreach (s[i]) send_byte(s[i], rnd);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, imem_wr_en, core_hold, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {rx_ready, imem_wr_en, core_hold, busy, done, error});
        end
        checks++;
        if ({imem_wr_addr, imem_wr_data} !== 64'h0) begin
            failures++;
            $display("FAIL reset_addr_data got=%h/%h want=0/0", imem_wr_addr, imem_wr_data);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rx_ready, busy, core_hold} !== 3'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=000", {rx_ready, busy, core_hold});
        end
    endtask

    task automatic test_good_load(input bit rnd);
        int w0;
        w0 = wr_count;
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        pulse_start();
        checks++;
        if ({busy, core_hold, done, error} !== 4'b1100) begin
            failures++;
            $display("FAIL good_start_flags rnd=%0d got=%b want=1100", rnd, {busy, core_hold, done, error});
        end
        send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                      8'h93, 8'h00, 8'h10, 8'h00, 8'hB6}, rnd);
        checks++;
        if ({done, error, core_hold, busy, rx_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL good_end_flags rnd=%0d got=%b want=10000", rnd,
                     {done, error, core_hold, busy, rx_ready});
        end
        checks++;
        if (wr_count - w0 != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL good_write_count rnd=%0d got=%0d want=2", rnd, wr_count - w0);
        end
        checks++;
        if (imem_wr_addr !== 32'h4 || imem_wr_data !== 32'h0010_0093) begin
            failures++;
            $display("FAIL good_hold got=%h/%h want=00000004/00100093", imem_wr_addr, imem_wr_data);
        end
    endtask

    task automatic test_bad_checksum();
        int w0;
        w0 = wr_count;
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        pulse_start();
        checks++;
        if ({done, busy} !== 2'b01) begin
            failures++;
            $display("FAIL done_clear_on_start got=%b want=01", {done, busy});
        end
        send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                      8'h93, 8'h00, 8'h10, 8'h00, 8'hB5}, 1'b0);
        checks++;
        if ({error, done, core_hold, busy} !== 4'b1010) begin
            failures++;
            $display("FAIL bad_chk_flags got=%b want=1010", {error, done, core_hold, busy});
        end
        checks++;
        if (wr_count - w0 != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bad_chk_writes got=%0d want=2", wr_count - w0);
        end
    endtask

    task automatic test_len_overflow();
        int w0;
        w0 = wr_count;
        pulse_start();
        checks++;
        if ({error, busy} !== 2'b01) begin
            failures++;
            $display("FAIL error_clear_on_start got=%b want=01", {error, busy});
        end
        send_stream('{8'h01, 8'h01}, 1'b0);
        checks++;
        if ({error, rx_ready, core_hold, busy} !== 4'b1010) begin
            failures++;
            $display("FAIL overflow_flags got=%b want=1010", {error, rx_ready, core_hold, busy});
        end
        rx_data = 8'hAA; rx_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        checks++;
        if (wr_count != w0 || error !== 1'b1) begin
            failures++;
            $display("FAIL overflow_no_write got=%0d/%b want=0/1", wr_count - w0, error);
        end
    endtask

    task automatic test_len_zero();
        int w0;
        w0 = wr_count;
        pulse_start();
        send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
        checks++;
        if ({done, error, core_hold} !== 3'b100 || wr_count != w0) begin
            failures++;
            $display("FAIL zero_len_good got=%b writes=%0d want=100 writes=0",
                     {done, error, core_hold}, wr_count - w0);
        end
        pulse_start();
        send_stream('{8'h00, 8'h00, 8'h01}, 1'b0);
        checks++;
        if ({done, error, core_hold} !== 3'b011 || wr_count != w0) begin
            failures++;
            $display("FAIL zero_len_bad got=%b writes=%0d want=011 writes=0",
                     {done, error, core_hold}, wr_count - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_count;
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        pulse_start();
        send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93}, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rx_ready, imem_wr_en, core_hold, busy, done, error} !== 6'b0 ||
            {imem_wr_addr, imem_wr_data} !== 64'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b %h/%h want=000000 0/0",
                     {rx_ready, imem_wr_en, core_hold, busy, done, error}, imem_wr_addr, imem_wr_data);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_count - w0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_writes got=%0d want=1", wr_count - w0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_good_load(1'b0);
        test_bad_checksum();
        test_len_overflow();
        test_len_zero();
        test_good_load(1'b1);
        test_reset_mid();
        test_good_load(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
IMEM_PROGRAM_LOADER -- requirements
Module: imem_program_loader

Interface
REQ-001 Parameter: IMEM_DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter: ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_data  input  8  incoming byte stream.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_ready  output  1  loader accepts the byte this cycle.
REQ-009 imem_wr_en  output  1  instruction memory write strobe, one cycle per word.
REQ-010 imem_wr_addr  output  32  byte address of the word being written.
REQ-011 imem_wr_data  output  32  instruction word being written.
REQ-012 core_hold  output  1  holds the fetch stage in reset while loading.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  last session completed successfully.
REQ-015 error  output  1  last session failed (length or checksum).

Function
REQ-016 A byte transfers only in a cycle where rx_valid and rx_ready are both 1.
REQ-017 The FSM shall have exactly these states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR.
REQ-018 IDLE, DONE and ERR shall go to LEN_LO on start; in all other states start is ignored.
REQ-019 LEN_LO: capture the first byte as word count bits [7:0], then go to LEN_HI.
REQ-020 LEN_HI: capture the second byte as word count bits [15:8]; go to CHK if the count is 0, ERR if the count exceeds IMEM_DEPTH, otherwise DATA.
REQ-021 DATA: assemble 4 bytes little-endian (the first byte lands in bits [7:0]); after the 4th byte, go to WRITE.
REQ-022 WRITE: for exactly one cycle, drive imem_wr_en=1 with imem_wr_addr = ADDR_BASE + 4*word_index and the assembled word on imem_wr_data.
REQ-023 On leaving WRITE: increment word_index; go to CHK if word_index reaches the count, otherwise DATA.
REQ-024 Checksum: 8-bit modulo-256 sum of all data bytes, excluding the length bytes.
REQ-025 CHK: accept one byte; go to DONE if it equals the checksum, otherwise ERR.
REQ-026 rx_ready shall be 1 in LEN_LO, LEN_HI, DATA and CHK, and 0 in IDLE, WRITE, DONE and ERR.
REQ-027 rx_valid=0 in any state shall stall that state indefinitely, with no timeout.
REQ-028 busy shall be 1 in LEN_LO through CHK inclusive.
REQ-029 core_hold shall be 1 whenever busy or in ERR, and 0 in IDLE and DONE.
REQ-030 done shall be 1 only in DONE; error shall be 1 only in ERR.
REQ-031 start in DONE or ERR shall clear done/error on the next cycle and restart at word_index 0, with the checksum cleared.
REQ-032 imem_wr_en shall never assert outside WRITE, so a partial session leaves earlier-written words intact.
REQ-033 imem_wr_addr and imem_wr_data shall hold their last values when imem_wr_en=0.

Reset
REQ-034 rst shall force state IDLE, word_index 0, byte counter 0 and checksum 0.
REQ-035 rst shall force all outputs to 0: rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data, core_hold, busy, done, error.
REQ-036 rst mid-session shall abort within the same edge, with no further write issued.
REQ-037 rst shall override a simultaneous start.

Structure
REQ-038 A shared package shall hold the state enum type, the length-field width (16) and the WORD_BYTES constant (4).
REQ-039 One sub-module, loader_word_assembler, shall perform the byte-to-word packing and byte count and provide a word-complete flag.
REQ-040 Implementation size shall be 120-400 lines of RTL; word_index shall be 16 bits wide.

Verification
REQ-041 Length 2, bytes 13 00 00 00 93 00 10 00, checksum 0xB6 -> writes 0x00000013 @0x0 and 0x00100093 @0x4, then done=1 and core_hold falls to 0.
REQ-042 Same stream with checksum 0xB5 -> both writes occur, then error=1, core_hold stays 1, done=0.
REQ-043 Length 0x0101 (257) with IMEM_DEPTH=256 -> ERR right after the second byte, no imem_wr_en ever, rx_ready=0.
REQ-044 Length 0, checksum byte 0x00 -> done=1 with zero writes; checksum byte 0x01 -> error=1.
REQ-045 rx_valid toggled randomly at 50% during REQ-041 -> identical writes and values; rx_ready=0 during each WRITE cycle.
REQ-046 rst pulsed after 5 data bytes of a length-2 session -> exactly one write (@0x0), all outputs 0 next cycle; a fresh start with REQ-041 data succeeds.
